// File: rtl/i2c_slave_regs_if.sv
// Host-side port bundle of i2c_slave_regs: local preload into the register
// file plus the write/read completion reporting back to the host logic.
interface i2c_slave_regs_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  LocalWe;
  logic [REG_ADDR_W-1:0] LocalAddr;
  logic [7:0]            LocalData;
  logic                  WriteDoneFlag;
  logic [REG_ADDR_W-1:0] WriteAddr;
  logic [7:0]            WriteData;
  logic                  ReadDoneFlag;

  modport slave (
    input  LocalWe, LocalAddr, LocalData,
    output WriteDoneFlag, WriteAddr, WriteData, ReadDoneFlag
  );

  modport master (
    output LocalWe, LocalAddr, LocalData,
    input  WriteDoneFlag, WriteAddr, WriteData, ReadDoneFlag
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C responder with a 2**REG_ADDR_W x 8 register file. Oversamples scl/sda on
// clk, answers register writes and the write-pointer / repeated-START / read
// sequence, and lets the host preload registers locally.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic              sdaModeExpose,
  i2c_slave_regs_if.slave   host
);
  localparam int DEPTH = 2 ** REG_ADDR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t                state;
  logic [2:0]            scl_pipe;
  logic [2:0]            sda_pipe;
  logic [3:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic [7:0]            tx_byte;
  logic [REG_ADDR_W-1:0] ptr;
  logic                  ack_phase;
  logic                  read_mode;
  logic                  sda_out;
  logic [7:0]            regs [DEPTH];

  logic                  scl_rise, scl_fall, sda_rise, sda_fall;
  logic                  start_cond, stop_cond, sda_bit;
  logic [7:0]            byte_in;
  logic [REG_ADDR_W-1:0] ptr_next;

  assign sda = sdaModeExpose ? sda_out : 1'bz;

  // Pipe index 1 is the synchronized level, index 2 the previous level used for edges.
  assign scl_rise   = scl_pipe[1] & ~scl_pipe[2];
  assign scl_fall   = ~scl_pipe[1] & scl_pipe[2];
  assign sda_rise   = sda_pipe[1] & ~sda_pipe[2];
  assign sda_fall   = ~sda_pipe[1] & sda_pipe[2];
  assign start_cond = sda_fall & scl_pipe[1];
  assign stop_cond  = sda_rise & scl_pipe[1];
  assign sda_bit    = sda_pipe[1];
  assign byte_in    = {shift_reg[6:0], sda_bit};
  assign ptr_next   = ptr + 1'b1;

  // Two synchronizer stages plus one edge-history stage for each bus line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl};
      sda_pipe <= {sda_pipe[1:0], sda};
    end
  end

  // Protocol FSM, register file, sda drive and host flags; an I2C commit is
  // written after the local preload so it wins on a same-index collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      shift_reg          <= '0;
      tx_byte            <= '0;
      ptr                <= '0;
      ack_phase          <= 1'b0;
      read_mode          <= 1'b0;
      sda_out            <= 1'b1;
      sdaModeExpose      <= 1'b0;
      host.WriteDoneFlag <= 1'b0;
      host.ReadDoneFlag  <= 1'b0;
      host.WriteAddr     <= '0;
      host.WriteData     <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      host.WriteDoneFlag <= 1'b0;
      host.ReadDoneFlag  <= 1'b0;
      if (host.LocalWe) regs[host.LocalAddr] <= host.LocalData;

      if (start_cond) begin
        state         <= ADDR;
        bit_cnt       <= '0;
        ack_phase     <= 1'b0;
        sdaModeExpose <= 1'b0;
      end else if (stop_cond) begin
        state         <= IDLE;
        bit_cnt       <= '0;
        ack_phase     <= 1'b0;
        sdaModeExpose <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: sdaModeExpose <= 1'b0;

          ADDR: if (scl_rise) begin
            shift_reg <= byte_in;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state     <= ADDR_ACK;
                read_mode <= byte_in[0];
                tx_byte   <= regs[ptr];
                ack_phase <= 1'b0;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          REG: if (scl_rise) begin
            shift_reg <= byte_in;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              ptr       <= byte_in[REG_ADDR_W-1:0];
              ack_phase <= 1'b0;
              state     <= REG_ACK;
            end
          end

          WDATA: if (scl_rise) begin
            shift_reg <= byte_in;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt            <= '0;
              regs[ptr]          <= byte_in;
              host.WriteDoneFlag <= 1'b1;
              host.WriteAddr     <= ptr;
              host.WriteData     <= byte_in;
              ack_phase          <= 1'b0;
              state              <= WDATA_ACK;
            end
          end

          ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase     <= 1'b1;
              sdaModeExpose <= 1'b1;
              sda_out       <= 1'b0;
            end else begin
              ack_phase     <= 1'b0;
              sdaModeExpose <= 1'b0;
              bit_cnt       <= '0;
              if (state == ADDR_ACK && read_mode) begin
                state         <= RDATA;
                sdaModeExpose <= 1'b1;
                sda_out       <= tx_byte[7];
                tx_byte       <= {tx_byte[6:0], 1'b0};
                bit_cnt       <= 4'd1;
              end else if (state == ADDR_ACK) begin
                state <= REG;
              end else if (state == REG_ACK) begin
                state <= WDATA;
              end else begin
                state <= WDATA;
                ptr   <= ptr_next;
              end
            end
          end

          RDATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sdaModeExpose <= 1'b0;
              bit_cnt       <= '0;
              ack_phase     <= 1'b0;
              state         <= RDATA_ACK;
            end else begin
              sdaModeExpose <= 1'b1;
              sda_out       <= tx_byte[7];
              tx_byte       <= {tx_byte[6:0], 1'b0};
              bit_cnt       <= bit_cnt + 4'd1;
            end
          end

          RDATA_ACK: begin
            if (scl_rise && !ack_phase) begin
              if (sda_bit) begin
                host.ReadDoneFlag <= 1'b1;
                state             <= WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
                ptr       <= ptr_next;
                tx_byte   <= regs[ptr_next];
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase     <= 1'b0;
              state         <= RDATA;
              sdaModeExpose <= 1'b1;
              sda_out       <= tx_byte[7];
              tx_byte       <= {tx_byte[6:0], 1'b0};
              bit_cnt       <= 4'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master plus host-port driver,
// with expected bytes, ACKs and write events queued as stimulus is issued.
module tb_i2c_slave_regs;
  localparam int         REG_ADDR_W = 4;
  localparam logic [6:0] SA         = 7'h50;
  localparam int         HALF       = 6;
  localparam int         PHASE      = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  logic sdaModeExpose;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regs_if #(.REG_ADDR_W(REG_ADDR_W)) host ();

  i2c_slave_regs #(.SLAVE_ADDR(SA), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .sdaModeExpose(sdaModeExpose), .host(host)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int wide_flags = 0;
  int expose_cycles = 0;
  logic wd_prev = 1'b0;
  logic rd_prev = 1'b0;

  logic [7:0]  exp_rd_q [$];
  logic [7:0]  obs_rd_q [$];
  logic        exp_ack_q [$];
  logic        obs_ack_q [$];
  logic [11:0] exp_wr_q [$];
  logic [11:0] obs_wr_q [$];

  // Flag monitor: counts pulses, catches over-wide pulses, records write events.
  always @(negedge clk) begin
    if (host.WriteDoneFlag) begin
      wr_pulses++;
      obs_wr_q.push_back({host.WriteAddr, host.WriteData});
      if (wd_prev) wide_flags++;
    end
    if (host.ReadDoneFlag) begin
      rd_pulses++;
      if (rd_prev) wide_flags++;
    end
    wd_prev = host.WriteDoneFlag;
    rd_prev = host.ReadDoneFlag;
    if (sdaModeExpose) expose_cycles++;
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic local_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host.LocalWe   = 1'b1;
    host.LocalAddr = a;
    host.LocalData = d;
    @(negedge clk);
    host.LocalWe   = 1'b0;
  endtask

  task automatic i2c_start;
    if (!scl) begin
      m_sda_low = 1'b0; clocks(HALF);
      scl = 1'b1;       clocks(HALF);
    end else begin
      m_sda_low = 1'b0; clocks(HALF);
    end
    m_sda_low = 1'b1; clocks(HALF);
    scl = 1'b0;       clocks(HALF);
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; clocks(HALF);
    scl = 1'b1;       clocks(HALF);
    m_sda_low = 1'b0; clocks(PHASE);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; clocks(HALF);
    scl = 1'b1;     clocks(PHASE);
    scl = 1'b0;     clocks(1);
    m_sda_low = 1'b0; clocks(HALF - 1);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; clocks(HALF);
    scl = 1'b1;       clocks(HALF);
    b = sda;          clocks(HALF);
    scl = 1'b0;       clocks(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    obs_ack_q.push_back(a);
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    obs_rd_q.push_back(d);
    send_bit(nack);
  endtask

  task automatic do_write(input logic [3:0] r, input logic [7:0] d);
    exp_wr_q.push_back({r, d});
    repeat (3) exp_ack_q.push_back(1'b0);
    i2c_start;
    write_byte({SA, 1'b0});
    write_byte({4'h0, r});
    write_byte(d);
    i2c_stop;
  endtask

  task automatic do_read(input logic [3:0] r, input int n);
    repeat (3) exp_ack_q.push_back(1'b0);
    i2c_start;
    write_byte({SA, 1'b0});
    write_byte({4'h0, r});
    i2c_start;
    write_byte({SA, 1'b1});
    for (int i = 0; i < n; i++) read_byte(i == n - 1);
    i2c_stop;
  endtask

  task automatic test_reset;
    clocks(4);
    checks++; if (sdaModeExpose !== 1'b0) begin errors++; $display("[TB] FAIL reset_expose got %b want 0", sdaModeExpose); end
    checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda got %b want 1", sda); end
    checks++; if (host.WriteDoneFlag !== 1'b0 || host.ReadDoneFlag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b want 00", host.WriteDoneFlag, host.ReadDoneFlag); end
    checks++; if (host.WriteAddr !== 4'h0 || host.WriteData !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata got %h/%h want 0/00", host.WriteAddr, host.WriteData); end
    rst = 1'b1;
    clocks(PHASE);
  endtask

  task automatic test_read_preload;
    int rd0;
    logic [7:0] e;
    logic ea;
    rd0 = rd_pulses;
    local_write(4'd3, 8'hA5);
    exp_rd_q.push_back(8'hA5);
    do_read(4'd3, 1);
    while (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      checks++;
      if (obs_ack_q.size() == 0) begin errors++; $display("[TB] FAIL read_ack missing want %b", ea); end
      else if (obs_ack_q[0] !== ea) begin errors++; $display("[TB] FAIL read_ack got %b want %b", obs_ack_q.pop_front(), ea); end
      else void'(obs_ack_q.pop_front());
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (obs_rd_q.size() == 0) begin errors++; $display("[TB] FAIL read_data missing want %h", e); end
      else if (obs_rd_q[0] !== e) begin errors++; $display("[TB] FAIL read_data got %h want %h", obs_rd_q.pop_front(), e); end
      else void'(obs_rd_q.pop_front());
    end
    checks++; if (rd_pulses - rd0 != 1) begin errors++; $display("[TB] FAIL read_done_count got %0d want 1", rd_pulses - rd0); end
    checks++; if (sdaModeExpose !== 1'b0) begin errors++; $display("[TB] FAIL read_idle_expose got %b want 0", sdaModeExpose); end
  endtask

  task automatic test_write;
    int wr0;
    logic [11:0] ew;
    logic [7:0] e;
    logic ea;
    wr0 = wr_pulses;
    do_write(4'd7, 8'h3C);
    checks++; if (wr_pulses - wr0 != 1) begin errors++; $display("[TB] FAIL write_done_count got %0d want 1", wr_pulses - wr0); end
    while (exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      checks++;
      if (obs_wr_q.size() == 0) begin errors++; $display("[TB] FAIL write_event missing want %h", ew); end
      else if (obs_wr_q[0] !== ew) begin errors++; $display("[TB] FAIL write_event got %h want %h", obs_wr_q.pop_front(), ew); end
      else void'(obs_wr_q.pop_front());
    end
    exp_rd_q.push_back(8'h3C);
    do_read(4'd7, 1);
    while (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      checks++;
      if (obs_ack_q.size() == 0) begin errors++; $display("[TB] FAIL write_ack missing want %b", ea); end
      else if (obs_ack_q[0] !== ea) begin errors++; $display("[TB] FAIL write_ack got %b want %b", obs_ack_q.pop_front(), ea); end
      else void'(obs_ack_q.pop_front());
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (obs_rd_q.size() == 0) begin errors++; $display("[TB] FAIL write_readback missing want %h", e); end
      else if (obs_rd_q[0] !== e) begin errors++; $display("[TB] FAIL write_readback got %h want %h", obs_rd_q.pop_front(), e); end
      else void'(obs_rd_q.pop_front());
    end
    checks++; if (wide_flags != 0) begin errors++; $display("[TB] FAIL flag_width got %0d wide pulses want 0", wide_flags); end
  endtask

  task automatic test_addr_mismatch;
    int wr0, rd0, ex0;
    logic ea;
    wr0 = wr_pulses; rd0 = rd_pulses; ex0 = expose_cycles;
    repeat (2) exp_ack_q.push_back(1'b1);
    i2c_start;
    write_byte({7'h51, 1'b0});
    write_byte(8'h02);
    i2c_stop;
    while (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      checks++;
      if (obs_ack_q.size() == 0) begin errors++; $display("[TB] FAIL mismatch_ack missing want %b", ea); end
      else if (obs_ack_q[0] !== ea) begin errors++; $display("[TB] FAIL mismatch_ack got %b want %b", obs_ack_q.pop_front(), ea); end
      else void'(obs_ack_q.pop_front());
    end
    checks++; if (expose_cycles != ex0) begin errors++; $display("[TB] FAIL mismatch_expose got %0d cycles want 0", expose_cycles - ex0); end
    checks++; if (wr_pulses != wr0 || rd_pulses != rd0) begin errors++; $display("[TB] FAIL mismatch_flags got %0d/%0d want 0/0", wr_pulses - wr0, rd_pulses - rd0); end
  endtask

  task automatic test_wrap;
    int rd0;
    logic [7:0] e;
    logic ea;
    rd0 = rd_pulses;
    local_write(4'd15, 8'h11);
    local_write(4'd0, 8'h22);
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    do_read(4'hF, 2);
    while (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      checks++;
      if (obs_ack_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_ack missing want %b", ea); end
      else if (obs_ack_q[0] !== ea) begin errors++; $display("[TB] FAIL wrap_ack got %b want %b", obs_ack_q.pop_front(), ea); end
      else void'(obs_ack_q.pop_front());
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (obs_rd_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_data missing want %h", e); end
      else if (obs_rd_q[0] !== e) begin errors++; $display("[TB] FAIL wrap_data got %h want %h", obs_rd_q.pop_front(), e); end
      else void'(obs_rd_q.pop_front());
    end
    checks++; if (rd_pulses - rd0 != 1) begin errors++; $display("[TB] FAIL wrap_done_count got %0d want 1", rd_pulses - rd0); end
  endtask

  task automatic test_stop_mid_write;
    int wr0;
    logic [7:0] e;
    logic ea;
    local_write(4'd5, 8'h6B);
    wr0 = wr_pulses;
    repeat (2) exp_ack_q.push_back(1'b0);
    i2c_start;
    write_byte({SA, 1'b0});
    write_byte(8'h05);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    i2c_stop;
    checks++; if (wr_pulses != wr0) begin errors++; $display("[TB] FAIL abort_write_flag got %0d want 0", wr_pulses - wr0); end
    checks++; if (sdaModeExpose !== 1'b0) begin errors++; $display("[TB] FAIL abort_expose got %b want 0", sdaModeExpose); end
    exp_rd_q.push_back(8'h6B);
    do_read(4'd5, 1);
    while (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      checks++;
      if (obs_ack_q.size() == 0) begin errors++; $display("[TB] FAIL abort_ack missing want %b", ea); end
      else if (obs_ack_q[0] !== ea) begin errors++; $display("[TB] FAIL abort_ack got %b want %b", obs_ack_q.pop_front(), ea); end
      else void'(obs_ack_q.pop_front());
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (obs_rd_q.size() == 0) begin errors++; $display("[TB] FAIL abort_reg missing want %h", e); end
      else if (obs_rd_q[0] !== e) begin errors++; $display("[TB] FAIL abort_reg got %h want %h", obs_rd_q.pop_front(), e); end
      else void'(obs_rd_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_read;
    logic b;
    logic [7:0] e;
    logic ea;
    repeat (3) exp_ack_q.push_back(1'b0);
    i2c_start;
    write_byte({SA, 1'b0});
    write_byte(8'h03);
    i2c_start;
    write_byte({SA, 1'b1});
    for (int i = 0; i < 3; i++) recv_bit(b);
    checks++; if (sdaModeExpose !== 1'b1 || sda !== 1'b0) begin errors++; $display("[TB] FAIL midread_bit4 got expose=%b sda=%b want 1/0", sdaModeExpose, sda); end
    rst = 1'b0;
    #1;
    checks++; if (sdaModeExpose !== 1'b0) begin errors++; $display("[TB] FAIL midread_reset_expose got %b want 0", sdaModeExpose); end
    checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL midread_reset_sda got %b want 1", sda); end
    clocks(3);
    rst = 1'b1;
    scl = 1'b1;
    m_sda_low = 1'b0;
    clocks(PHASE);
    exp_rd_q.push_back(8'h00);
    do_read(4'd3, 1);
    do_write(4'd2, 8'h5A);
    exp_rd_q.push_back(8'h5A);
    do_read(4'd2, 1);
    while (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      checks++;
      if (obs_ack_q.size() == 0) begin errors++; $display("[TB] FAIL midread_ack missing want %b", ea); end
      else if (obs_ack_q[0] !== ea) begin errors++; $display("[TB] FAIL midread_ack got %b want %b", obs_ack_q.pop_front(), ea); end
      else void'(obs_ack_q.pop_front());
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (obs_rd_q.size() == 0) begin errors++; $display("[TB] FAIL midread_data missing want %h", e); end
      else if (obs_rd_q[0] !== e) begin errors++; $display("[TB] FAIL midread_data got %h want %h", obs_rd_q.pop_front(), e); end
      else void'(obs_rd_q.pop_front());
    end
  endtask

  initial begin
    host.LocalWe   = 1'b0;
    host.LocalAddr = '0;
    host.LocalData = '0;
    test_reset;
    test_read_preload;
    test_write;
    test_addr_mismatch;
    test_wrap;
    test_stop_mid_write;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C responder (slave) holding a small 8-bit register file, answering the register-read transaction our I2C read master issues (START, addr+W, reg, repeated START, addr+R, data, NACK, STOP) as well as register writes. It sits on the same scl/sda bus as the master. It oversamples scl/sda on the system clock and exposes a local preload port plus write/read completion flags to the host logic.

## Interface

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address this block responds to
- REG_ADDR_W, 4, register-index width; depth = 2**REG_ADDR_W (16)

Ports:
- clk  input  1  system clock; one clock domain for the whole block
- rst  input  1  asynchronous, active-low reset
- scl  input  1  I2C serial clock from the master
- sda  inout  1  I2C data line; driven only while sdaModeExpose=1, otherwise high-Z
- sdaModeExpose  output  1  1 = block is driving sda
- LocalWe  input  1  host preload strobe
- LocalAddr  input  REG_ADDR_W  host preload index
- LocalData  input  8  host preload data
- WriteDoneFlag  output  1  one-cycle pulse when an I2C write byte is committed
- WriteAddr  output  REG_ADDR_W  index of the last committed I2C write
- WriteData  output  8  data of the last committed I2C write
- ReadDoneFlag  output  1  one-cycle pulse when the master NACKs a read byte

## Operation

- scl/sda pass through 2-flop synchronizers. Edges are detected on the synchronized values.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are recognized in every state.
  - START always goes to ADDR (this covers repeated START) with the bit count cleared.
  - STOP always goes to IDLE and releases sda.
- Bits are sampled on the scl rising edge. The slave changes sda on the scl falling edge.
- States:
  - IDLE: sda released; waits for START.
  - ADDR: shifts 8 bits MSB first. If bits[7:1]==SLAVE_ADDR, go to ADDR_ACK. Otherwise go to WAIT_STOP with sda never driven.
  - ADDR_ACK: drive 0 for the 9th bit. Next state is REG if R/W=0. If R/W=1, next state is RDATA with the byte reg[ptr] loaded.
  - REG: shift 8 bits. ptr <= low REG_ADDR_W bits; upper bits are ignored. Then REG_ACK, which drives 0, then WDATA.
  - WDATA: shift 8 bits. On the 8th sample, commit reg[ptr]; pulse WriteDoneFlag; set WriteAddr=ptr and WriteData=byte. Then WDATA_ACK drives 0 and ptr increments modulo depth; next state is WDATA for multi-byte writes.
  - RDATA: drive bits MSB first, starting on the falling edge that ends the preceding ACK. Release sda on the falling edge after bit 0, then go to RDATA_ACK.
  - RDATA_ACK: sample the master's bit.
    - 0 (ACK): ptr increments modulo depth, load reg[ptr], go to RDATA.
    - 1 (NACK): pulse ReadDoneFlag, go to WAIT_STOP.
  - WAIT_STOP: sda released; waits for STOP or START.
- ACK drive timing: starts on the falling edge after the 8th bit and is released on the falling edge after the 9th bit.
- Local preload: when LocalWe=1, reg[LocalAddr]<=LocalData in that cycle. If it collides with an I2C commit to the same index in the same cycle, the I2C commit wins.
- Register file resets to 8'h00. ptr resets to 0 and is retained across transactions, so a read with no REG phase continues from ptr.

## Timing

- Reset (async, rst=0) takes effect immediately, including mid-transaction:
  - State=IDLE and sdaModeExpose=0 (sda high-Z).
  - WriteDoneFlag=0, ReadDoneFlag=0, WriteAddr=0, WriteData=0.
  - All registers and ptr are 0.
- Edge-detect latency: 3 clk from a bus pin change to the internal event (2 synchronizer stages plus 1 edge register).
- sda drive change: at most 4 clk after the actual scl fall.
- scl high and low phases must each be at least 6 clk. The master's 12/13-clk phases satisfy this.
- Flags are exactly one clk wide and registered. WriteDoneFlag asserts 1 clk after the 8th WDATA sample edge is detected.
- A START or STOP in the middle of a byte aborts that byte: no commit, no flag.

## Test plan

- Preload reg[3]=8'hA5 via LocalWe; master reads addr 0x50, reg 0x03 -> ACK (sda=0) at all three ACK slots, master gets 8'hA5, one ReadDoneFlag pulse after the NACK, IDLE after STOP.
- I2C write to addr 0x50, reg 0x07, data 0x3C -> three ACKs, WriteDoneFlag 1 clk with WriteAddr=7 and WriteData=8'h3C; a subsequent read of reg 0x07 returns 8'h3C.
- Address 0x51 (mismatch) -> sdaModeExpose stays 0 for the whole transaction, master samples ACK=1, no flags.
- Preload reg[15]=8'h11 and reg[0]=8'h22; read from reg 0x0F with master ACK after the first byte, then NACK -> bytes 8'h11, 8'h22 (wrap-around), one ReadDoneFlag.
- rst pulled low while driving bit 4 of a read byte -> sdaModeExpose=0 the same instant, registers read 0. After release, a write/read of reg 2 = 8'h5A succeeds.
- STOP issued after 4 bits of WDATA -> IDLE, no WriteDoneFlag, target register unchanged.
